// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES byte/column/state types, GF(2^8) helpers and FSM states
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  col_t;
  typedef logic [127:0] state_t;

  localparam byte_t AES_POLY = 8'h1b;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_state_t;

  function automatic byte_t xtime(input byte_t v);
    return {v[6:0], 1'b0} ^ (v[7] ? AES_POLY : 8'h00);
  endfunction

  // Column c occupies bytes 4c..4c+3, counted from the MSB end of the state
  function automatic col_t get_col(input state_t s, input logic [1:0] c);
    col_t r;
    case (c)
      2'd0:    r = s[127:96];
      2'd1:    r = s[95:64];
      2'd2:    r = s[63:32];
      default: r = s[31:0];
    endcase
    return r;
  endfunction

  function automatic state_t set_col(input state_t s, input logic [1:0] c, input col_t v);
    state_t r;
    r = s;
    case (c)
      2'd0:    r[127:96] = v;
      2'd1:    r[95:64]  = v;
      2'd2:    r[63:32]  = v;
      default: r[31:0]   = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mixcolumns_col.sv
// rtl/mixcolumns_col.sv - combinational single-column MixColumns / InvMixColumns
module mixcolumns_col
  import aes_pkg::*;
#(
  parameter int INV_EN = 1
) (
  input  col_t col_in,
  input  logic inv,
  output col_t col_out
);

  logic  pre_en;
  byte_t u, v;
  byte_t a, b, c, d;

  // InvMixColumns factors as a cheap pre-multiply followed by the forward matrix
  assign pre_en = (INV_EN != 0) && inv;
  assign u = pre_en ? xtime(xtime(col_in[31:24] ^ col_in[15:8])) : 8'h00;
  assign v = pre_en ? xtime(xtime(col_in[23:16] ^ col_in[7:0]))  : 8'h00;

  assign a = col_in[31:24] ^ u;
  assign b = col_in[23:16] ^ v;
  assign c = col_in[15:8]  ^ u;
  assign d = col_in[7:0]   ^ v;

  assign col_out = {xtime(a ^ b) ^ b ^ c ^ d,
                    xtime(b ^ c) ^ c ^ d ^ a,
                    xtime(c ^ d) ^ d ^ a ^ b,
                    xtime(d ^ a) ^ a ^ b ^ c};

endmodule

// File: rtl/mixcolumns_iter.sv
// rtl/mixcolumns_iter.sv - iterative handshaked MixColumns engine, COLS_PER_CYCLE columns per clock
module mixcolumns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter int INV_EN         = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mixcolumns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE % 4);
  localparam logic [1:0] LAST_CNT = 2'((4 - COLS_PER_CYCLE) % 4);

  fsm_state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  state_t     data_q, data_d;
  logic       mode_q, mode_d;
  col_t       mixed [COLS_PER_CYCLE];

  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_col
    mixcolumns_col #(.INV_EN(INV_EN)) u_col (
      .col_in  (get_col(data_q, cnt_q + 2'(j))),
      .inv     (mode_q),
      .col_out (mixed[j])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      data_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_state;
          mode_d  = in_inv && (INV_EN != 0);
          cnt_d   = 2'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Columns are rewritten in place; the counter wraps to 0 after the last group
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
          data_d = set_col(data_d, cnt_q + 2'(j), mixed[j]);
        end
        cnt_d = cnt_q + CNT_STEP;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_state = data_q;

endmodule

// File: tb/tb_mixcolumns_iter.sv
// tb/tb_mixcolumns_iter.sv - directed self-checking bench for mixcolumns_iter
module tb_mixcolumns_iter;

  localparam logic [127:0] S0   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] M0   = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] VIN  = 128'hdb135345f20a225cc6c6c6c6d4d4d4d5;
  localparam logic [127:0] VOUT = 128'h8e4da1bc9fdc589dc6c6c6c6d5d5d7d6;
  localparam logic [127:0] V2IN  = 128'h2d26314c2d26314cdb135345c6c6c6c6;
  localparam logic [127:0] V2OUT = 128'h4d7ebdf84d7ebdf88e4da1bcc6c6c6c6;
  localparam logic [127:0] IVIN  = 128'h8e4da1bc8e4da1bc8e4da1bc8e4da1bc;
  localparam logic [127:0] IVOUT = 128'hdb135345db135345db135345db135345;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0]   in_valid = '0;
  logic [3:0]   in_inv = '0;
  logic [3:0]   out_ready = '0;
  logic [127:0] in_state [4];
  wire  [3:0]   in_ready;
  wire  [3:0]   out_valid;
  wire  [3:0]   busy;
  wire  [127:0] out_state [4];

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Instances: 0 -> 1 col/cycle, 1 -> 2, 2 -> 4, 3 -> 1 col/cycle without inverse support
  for (genvar g = 0; g < 4; g++) begin : g_dut
    mixcolumns_iter #(
      .COLS_PER_CYCLE (g == 1 ? 2 : (g == 2 ? 4 : 1)),
      .INV_EN         (g == 3 ? 0 : 1)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_inv    (in_inv[g]),
      .in_state  (in_state[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .busy      (busy[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; returns in the same phase after the output handshake
  task automatic run_txn(input int i, input logic [127:0] st, input logic inv,
                         input logic [127:0] exp, input int exp_lat, input string tag);
    int lat;
    in_state[i] = st;
    in_inv[i]   = inv;
    in_valid[i] = 1'b1;
    check({tag, "/in_ready"}, in_ready[i], 1);
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
    lat = 1;
    while (!out_valid[i] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, lat, exp_lat);
    check({tag, "/out_valid"}, out_valid[i], 1);
    check({tag, "/out_state"}, out_state[i], exp);
    out_ready[i] = 1'b1;
    @(posedge clk); #1;
    out_ready[i] = 1'b0;
    check({tag, "/valid_drop"}, out_valid[i], 0);
    check({tag, "/ready_back"}, in_ready[i], 1);
  endtask

  initial begin
    int lat;
    int first;
    int second;
    for (int i = 0; i < 4; i++) in_state[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst/in_ready", in_ready[0], 1);
    check("rst/out_valid", out_valid[0], 0);
    check("rst/out_state", out_state[0], 0);
    check("rst/busy", busy[0], 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst/in_ready_rel", in_ready, 4'hf);

    // Full-state forward and inverse on every width
    for (int i = 0; i < 3; i++) begin
      run_txn(i, S0, 1'b0, M0, (i == 0) ? 5 : ((i == 1) ? 3 : 2), $sformatf("fwd%0d", i));
      run_txn(i, M0, 1'b1, S0, (i == 0) ? 5 : ((i == 1) ? 3 : 2), $sformatf("inv%0d", i));
    end

    // Column vectors at every column position
    run_txn(1, VIN, 1'b0, VOUT, 3, "colvec");
    for (int c = 0; c < 4; c++)
      check($sformatf("colvec/col%0d", c), out_state[1][127-32*c -: 32], VOUT[127-32*c -: 32]);
    run_txn(2, V2IN, 1'b0, V2OUT, 2, "colvec2");
    run_txn(0, IVIN, 1'b1, IVOUT, 5, "invcol");

    // Backpressure in DONE with a competing input request
    in_state[0] = S0;
    in_inv[0]   = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp/reach_done", out_valid[0], 1);
    in_state[0] = VIN;
    in_valid[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("bp/out_valid", out_valid[0], 1);
      check("bp/out_state", out_state[0], M0);
      check("bp/busy", busy[0], 1);
      check("bp/in_ready", in_ready[0], 0);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    check("bp/ready_after", in_ready[0], 1);
    check("bp/valid_after", out_valid[0], 0);
    check("bp/not_latched", out_state[0], M0);

    // Asynchronous reset after two of four columns
    in_state[0] = S0;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("arst/busy_before", busy[0], 1);
    rst_n = 1'b0;
    #1;
    check("arst/out_valid", out_valid[0], 0);
    check("arst/out_state", out_state[0], 0);
    check("arst/busy", busy[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst/in_ready", in_ready[0], 1);
    run_txn(0, VIN, 1'b0, VOUT, 5, "arst_next");

    // Build without inverse: in_inv is ignored
    run_txn(3, VIN, 1'b1, VOUT, 5, "noinv_col");
    run_txn(3, S0, 1'b1, M0, 5, "noinv_state");

    // Back-to-back throughput with out_ready held high
    for (int i = 0; i < 3; i++) begin
      in_state[i]  = S0;
      in_inv[i]    = 1'b0;
      in_valid[i]  = 1'b1;
      out_ready[i] = 1'b1;
      first  = -1;
      second = -1;
      for (int c = 0; c < 40 && second < 0; c++) begin
        @(posedge clk); #1;
        if (out_valid[i]) begin
          check($sformatf("tput%0d/state", i), out_state[i], M0);
          if (first < 0) first = c;
          else second = c;
        end
      end
      in_valid[i] = 1'b0;
      check($sformatf("tput%0d/period", i), second - first, (i == 0) ? 6 : ((i == 1) ? 4 : 3));
      @(posedge clk); #1;
      out_ready[i] = 1'b0;
      check($sformatf("tput%0d/idle", i), in_ready[i], 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
